// File: rtl/fft_pkg.sv
// Shared constants, bank-state encoding and index helper for the FFT input buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fft_pkg;

    localparam int DATA_W = 16;
    localparam int N_PTS  = 16;
    localparam int LOG2_N = $clog2(N_PTS);

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_t;

    // Reverse the low 'bits' bits of idx; used to place samples in DIT input order.
    function automatic int unsigned bitrev(input int unsigned idx, input int unsigned bits);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (i < int'(bits)) begin
                r = r | (((idx >> i) & 32'd1) << (bits - 32'd1 - 32'(i)));
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_in_bank.sv
// One frame bank: N_PTS sample registers with indexed write, bulk clear and parallel read-out.
// Latency: a write is visible on rd_dat the cycle after wr_en.
// Backpressure: none; the caller decides when to write or clear.
module fft_in_bank #(
    parameter int DATA_W = 16,
    parameter int N_PTS  = 16,
    parameter int IDX_W  = $clog2(N_PTS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic              clr,
    output logic [DATA_W-1:0] rd_dat [0:N_PTS-1]
);

    // Sample storage; clear wins over write (the parent never asserts both).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_PTS; i++) begin
                rd_dat[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < N_PTS; i++) begin
                rd_dat[i] <= '0;
            end
        end else if (wr_en) begin
            rd_dat[wr_idx] <= wr_dat;
        end
    end

endmodule

// File: rtl/fft_input_buffer.sv
// Ping-pong frame buffer feeding an FFT; optional DIT bit-reversed store via FFT_IN_BITREV_EN.
// Latency: valid_o rises the cycle after the last sample of a frame is accepted.
// Backpressure: s_ready_o drops only when both banks hold full frames (or during flush_i).
module fft_input_buffer #(
    parameter int DATA_W = fft_pkg::DATA_W,
    parameter int N_PTS  = fft_pkg::N_PTS
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              s_valid_i,
    input  logic [DATA_W-1:0] s_data_i,
    output logic              s_ready_o,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] x_re_o [0:N_PTS-1]
);

    import fft_pkg::*;

    localparam int IDX_W = $clog2(N_PTS);

    logic [IDX_W-1:0]  wr_cnt;
    logic [IDX_W-1:0]  wr_idx;
    logic              wr_bank;
    logic              rd_bank;
    logic              init_done;
    bank_state_t       bank_st [2];
    logic              in_acc;
    logic              out_hs;
    logic              wr_last;
    logic [DATA_W-1:0] bank0_dat [0:N_PTS-1];
    logic [DATA_W-1:0] bank1_dat [0:N_PTS-1];

    // init_done keeps s_ready_o low while reset is held and for nothing longer.
    assign s_ready_o = init_done && !flush_i && (bank_st[wr_bank] != BANK_FULL);
    assign valid_o   = (bank_st[rd_bank] == BANK_FULL);
    assign in_acc    = s_valid_i && s_ready_o;
    assign out_hs    = valid_o && ready_i;
    assign wr_last   = (wr_cnt == IDX_W'(N_PTS - 1));

`ifdef FFT_IN_BITREV_EN
    assign wr_idx = IDX_W'(bitrev(32'(wr_cnt), IDX_W));
`else
    assign wr_idx = wr_cnt;
`endif

    // Bank state, write pointer/counter and read pointer. The handshake always targets a
    // FULL bank and a write never does, so both may act in the same cycle without conflict.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bank_st[0] <= BANK_EMPTY;
            bank_st[1] <= BANK_EMPTY;
            wr_cnt     <= '0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            init_done  <= 1'b0;
        end else begin
            init_done <= 1'b1;
            if (out_hs) begin
                bank_st[rd_bank] <= BANK_EMPTY;
                rd_bank          <= ~rd_bank;
            end
            if (flush_i) begin
                wr_cnt <= '0;
                if (bank_st[wr_bank] == BANK_FILLING) begin
                    bank_st[wr_bank] <= BANK_EMPTY;
                end
            end else if (in_acc) begin
                if (wr_last) begin
                    bank_st[wr_bank] <= BANK_FULL;
                    wr_bank          <= ~wr_bank;
                    wr_cnt           <= '0;
                end else begin
                    bank_st[wr_bank] <= BANK_FILLING;
                    wr_cnt           <= wr_cnt + 1'b1;
                end
            end
        end
    end

    fft_in_bank #(
        .DATA_W (DATA_W),
        .N_PTS  (N_PTS),
        .IDX_W  (IDX_W)
    ) u_bank0 (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .wr_en  (in_acc && !wr_bank),
        .wr_idx (wr_idx),
        .wr_dat (s_data_i),
        .clr    (flush_i && !wr_bank && (bank_st[0] == BANK_FILLING)),
        .rd_dat (bank0_dat)
    );

    fft_in_bank #(
        .DATA_W (DATA_W),
        .N_PTS  (N_PTS),
        .IDX_W  (IDX_W)
    ) u_bank1 (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .wr_en  (in_acc && wr_bank),
        .wr_idx (wr_idx),
        .wr_dat (s_data_i),
        .clr    (flush_i && wr_bank && (bank_st[1] == BANK_FILLING)),
        .rd_dat (bank1_dat)
    );

    // Present the bank the read pointer selects; it only moves on a handshake.
    always_comb begin
        for (int i = 0; i < N_PTS; i++) begin
            x_re_o[i] = rd_bank ? bank1_dat[i] : bank0_dat[i];
        end
    end

endmodule

// File: tb/tb_fft_input_buffer.sv
// Self-checking bench for fft_input_buffer: vector table, directed corner sequences, random traffic.
// Latency: reference model tracks frames as queues, checked every cycle.
// Backpressure: model expects s_ready low only with two complete frames pending or flush high.
module tb_fft_input_buffer;

    localparam int DW = 16;
    localparam int NP = 16;

    typedef logic [DW-1:0] frame_t [NP];

    typedef struct {
        int rep;
        bit rst;
        bit vld;
        int base;
        bit flush;
        bit rdy;
        bit exp_rdy;
        bit exp_vld;
    } vec_t;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data  = '0;
    logic          flush   = 1'b0;
    logic          ready   = 1'b0;
    logic          s_ready;
    logic          valid;
    logic [DW-1:0] x_re [0:NP-1];

    int total = 0;
    int bad   = 0;

    frame_t        full_q [$];
    logic [DW-1:0] part_q [$];
    bit            m_alive = 1'b0;
    bit            act_rdy;
    bit            act_vld;
    vec_t          tbl [13];

    always #5 clk = ~clk;

    fft_input_buffer #(
        .DATA_W (DW),
        .N_PTS  (NP)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .s_valid_i (s_valid),
        .s_data_i  (s_data),
        .s_ready_o (s_ready),
        .flush_i   (flush),
        .valid_o   (valid),
        .ready_i   (ready),
        .x_re_o    (x_re)
    );

    // Where sample n of a frame is expected to appear on x_re.
    function automatic int tb_pos(input int n);
`ifdef FFT_IN_BITREV_EN
        int r;
        r = 0;
        for (int b = 0; b < 4; b++) begin
            if ((n & (1 << b)) != 0) r = r + (1 << (3 - b));
        end
        return r;
`else
        return n;
`endif
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_frame(input string nm, input frame_t ef);
        int errs;
        int first;
        errs  = 0;
        first = -1;
        for (int n = 0; n < NP; n++) begin
            if (x_re[tb_pos(n)] !== ef[n]) begin
                if (first < 0) first = n;
                errs++;
            end
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL %s: %0d samples differ, sample %0d got %h expected %h",
                     nm, errs, first, x_re[tb_pos(first)], ef[first]);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, then advance the model.
    task automatic step(input bit v, input logic [DW-1:0] d, input bit f, input bit r);
        bit     exp_rdy;
        bit     exp_vld;
        bit     acc;
        bit     hs;
        frame_t fr;
        @(negedge clk);
        s_valid = v;
        s_data  = d;
        flush   = f;
        ready   = r;
        #1;
        exp_rdy = m_alive && !f && (full_q.size() < 2);
        exp_vld = (full_q.size() > 0);
        act_rdy = s_ready;
        act_vld = valid;
        check("s_ready", 32'(s_ready), 32'(exp_rdy));
        check("valid", 32'(valid), 32'(exp_vld));
        if (exp_vld) check_frame("frame", full_q[0]);
        acc = v && exp_rdy;
        hs  = exp_vld && r;
        @(posedge clk);
        if (hs) void'(full_q.pop_front());
        if (f) begin
            part_q.delete();
        end else if (acc) begin
            part_q.push_back(d);
            if (part_q.size() == NP) begin
                for (int n = 0; n < NP; n++) fr[n] = part_q[n];
                full_q.push_back(fr);
                part_q.delete();
            end
        end
        m_alive = 1'b1;
    endtask

    // Assert reset at a negedge, check the asynchronous clear, then release it.
    task automatic do_reset();
        int nz;
        @(negedge clk);
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        flush   = 1'b0;
        ready   = 1'b0;
        #1;
        check("rst_valid", 32'(valid), 0);
        check("rst_s_ready", 32'(s_ready), 0);
        nz = 0;
        for (int i = 0; i < NP; i++) if (x_re[i] !== '0) nz++;
        check("rst_x_re_nonzero", 32'(nz), 0);
        full_q.delete();
        part_q.delete();
        m_alive = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        m_alive = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{16, 1'b1, 1'b1, 0,       1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{16, 1'b0, 1'b1, 16,      1'b0, 1'b0, 1'b1, 1'b1};
        tbl[2]  = '{2,  1'b0, 1'b1, 32,      1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1,  1'b0, 1'b1, 32,      1'b0, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{1,  1'b0, 1'b1, 32,      1'b0, 1'b1, 1'b1, 1'b1};
        tbl[5]  = '{15, 1'b0, 1'b1, 33,      1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1,  1'b0, 1'b0, 0,       1'b0, 1'b1, 1'b1, 1'b1};
        tbl[7]  = '{1,  1'b0, 1'b0, 0,       1'b0, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1,  1'b1, 1'b1, 'h7FFF,  1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{15, 1'b0, 1'b1, 200,     1'b0, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1,  1'b0, 1'b0, 0,       1'b0, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1,  1'b0, 1'b1, 215,     1'b0, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{1,  1'b0, 1'b0, 0,       1'b0, 1'b1, 1'b1, 1'b1};

        // Basic frame: 0..15 at one per cycle, valid the cycle after the last sample.
        do_reset();
        for (int i = 0; i < NP; i++) step(1'b1, DW'(i), 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check("basic_valid", 32'(valid), 1);
`ifdef FFT_IN_BITREV_EN
        check("basic_x1", 32'(x_re[1]), 8);
        check("basic_x3", 32'(x_re[3]), 12);
`else
        for (int i = 0; i < NP; i++) check($sformatf("basic_x%0d", i), 32'(x_re[i]), 32'(i));
`endif
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);

        // Sustained streaming with the sink always ready.
        for (int i = 0; i < 64; i++) step(1'b1, DW'($urandom), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1);

        // Vector table: backpressure with two frames pending, then flush-vs-valid priority.
        for (int t = 0; t < 13; t++) begin
            if (tbl[t].rst) do_reset();
            for (int k = 0; k < tbl[t].rep; k++) begin
                step(tbl[t].vld, DW'(tbl[t].base + k), tbl[t].flush, tbl[t].rdy);
                check($sformatf("tbl%0d_s_ready", t), 32'(act_rdy), 32'(tbl[t].exp_rdy));
                check($sformatf("tbl%0d_valid", t), 32'(act_vld), 32'(tbl[t].exp_vld));
            end
        end

        // Partial frame discarded by flush, next frame 100..115 intact.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, DW'(i + 1), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < NP; i++) step(1'b1, DW'(100 + i), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);

        // Reset mid-frame while a full frame waits, then a fresh frame.
        do_reset();
        for (int i = 0; i < NP + 9; i++) step(1'b1, DW'(i + 16), 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < NP; i++) step(1'b1, DW'(300 + i), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);

        // Extreme values alternating.
        for (int i = 0; i < 2 * NP; i++) step(1'b1, (i % 2 == 0) ? DW'('h8000) : DW'('h7FFF), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1);

        // Random traffic with occasional flush and random sink readiness.
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 19) == 0,
                 $urandom_range(0, 1) == 1);
        end
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
